// File: rtl/avg_ram_pkg.sv
// Shared types and default sizing for the averager sample-RAM arbiter.
package avg_ram_pkg;

    localparam int AW_DEF         = 4;
    localparam int DW_DEF         = 8;
    localparam int STARVE_MAX_DEF = 3;

    // Which requester owns the RAM port this cycle.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WR   = 2'd1,
        ARB_RD   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/avg_ram_ptrs.sv
// Circular-buffer bookkeeping: write/read pointers, occupancy and flags.
// Pointers wrap naturally because DEPTH is a power of two.
module avg_ram_ptrs #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc_wr,
    input  logic          inc_rd,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Advance pointers and occupancy on the strobes; only one access per cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (inc_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (inc_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (inc_wr && !inc_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (inc_rd && !inc_wr) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);

endmodule

// File: rtl/avg_ram_arb.sv
// Arbiter for the single-port sample RAM shared by the averager write path
// and the readout client. A grant decided in one cycle drives the RAM port
// from registers in the next; pointers and count move on the granting edge,
// so decisions made during a granted cycle already see the updated count.
module avg_ram_arb
    import avg_ram_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    input  logic          ovf_clr,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int          SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    logic          wp_valid_q, wp_valid_d;
    logic [DW-1:0] wp_data_q, wp_data_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q, rd_valid_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_elig, rd_elig, commit, rd_take, drop, discard;

    avg_ram_ptrs #(.AW(AW)) u_ptrs (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_wr  (commit),
        .inc_rd  (rd_take),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Arbitration, pending slot, starvation and overflow next-state logic.
    always_comb begin
        wr_elig = wp_valid_q && !full;
        rd_elig = rd_req && !empty;

        state_d = ARB_IDLE;
        if (wr_elig && rd_elig) begin
            state_d = (starve_cnt_q == STARVE_LIM) ? ARB_RD : ARB_WR;
        end else if (wr_elig) begin
            state_d = ARB_WR;
        end else if (rd_elig) begin
            state_d = ARB_RD;
        end

        commit  = (state_d == ARB_WR);
        rd_take = (state_d == ARB_RD);
        // A full buffer cannot take the pending average; it is thrown away.
        discard = wp_valid_q && full;
        drop    = wr_req && wp_valid_q && !commit;

        starve_cnt_d = starve_cnt_q;
        if (!rd_req || rd_take) begin
            starve_cnt_d = '0;
        end else if (wr_elig && rd_elig && commit && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        wp_valid_d = wp_valid_q;
        wp_data_d  = wp_data_q;
        if (wr_req && (!wp_valid_q || commit)) begin
            wp_valid_d = 1'b1;
            wp_data_d  = wr_data;
        end else if (commit || discard) begin
            wp_valid_d = 1'b0;
        end

        // A new drop outranks a simultaneous clear.
        overflow_d = overflow_q;
        if (drop || discard) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (commit) begin
            ram_addr_d  = wr_ptr;
            ram_wdata_d = wp_data_q;
        end else if (rd_take) begin
            ram_addr_d = rd_ptr;
        end

        rd_valid_d = (state_q == ARB_RD);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            wp_valid_q   <= 1'b0;
            wp_data_q    <= '0;
            starve_cnt_q <= '0;
            overflow_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wp_valid_q   <= wp_valid_d;
            wp_data_q    <= wp_data_d;
            starve_cnt_q <= starve_cnt_d;
            overflow_q   <= overflow_d;
            rd_valid_q   <= rd_valid_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign ram_we    = (state_q == ARB_WR);
    assign rd_gnt    = (state_q == ARB_RD);
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = ram_rdata;
    assign overflow  = overflow_q;

endmodule

// File: doc/avg_ram_arb.md
Name: avg_ram_arb

Overview:
- Arbitrates the single-port sample RAM in the 50 MHz subsystem.
- Two requesters share it:
  - the averager write path: one-cycle write pulses carrying finished averages;
  - a readout client: level-held read requests.
- The RAM is managed as a circular buffer with write/read pointers, occupancy count, full/empty flags and a sticky overflow flag.
- A starvation limit stops continuous averager traffic from locking out readout.

Parameters:
- AW, 4, RAM address width; DEPTH = 2**AW entries.
- DW, 8, data width of averages and RAM words.
- STARVE_MAX, 3, blocked-read cycles after which the read wins one arbitration.

Ports:
- clk  in  1  50 MHz clock
- reset_n  in  1  asynchronous, active-low reset
- wr_req  in  1  one-cycle pulse: wr_data holds a new average
- wr_data  in  DW  average to store, valid with wr_req
- rd_req  in  1  readout request, held high until rd_gnt
- ovf_clr  in  1  one-cycle pulse that clears overflow
- ram_rdata  in  DW  RAM read data, valid one cycle after a read address
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- rd_gnt  out  1  one-cycle pulse: read accepted this cycle
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  DW  read data (passthrough of ram_rdata)
- count  out  AW+1  entries stored, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: an average was dropped

Behaviour:
- Reset values:
  - all registers 0 and state ARB_IDLE;
  - ram_we, rd_gnt, rd_valid, overflow, full = 0;
  - empty = 1, count = 0, ram_addr = 0.
- Pending write slot (wp_valid, wp_data):
  - wr_req loads it.
  - wr_req while wp_valid=1 and the slot is not committed in the same cycle: new data dropped, overflow <= 1.
  - wr_req in the same cycle the slot commits: new data loads, no overflow.
- Eligibility:
  - write eligible = wp_valid && !full;
  - read eligible = rd_req && !empty.
  - wp_valid && full: slot is discarded at that edge and overflow <= 1.
  - rd_req while empty: waits, no grant.
- FSM states ARB_IDLE, ARB_WR, ARB_RD. Next state is evaluated every cycle from any state, so back-to-back grants need no idle cycle:
  - both eligible and starve_cnt < STARVE_MAX -> ARB_WR;
  - both eligible and starve_cnt == STARVE_MAX -> ARB_RD;
  - only one eligible -> that state;
  - neither -> ARB_IDLE.
- In ARB_WR:
  - ram_we=1, ram_addr=wr_ptr, ram_wdata=wp_data;
  - at the edge: wr_ptr++ (wraps DEPTH-1 -> 0), count++, wp_valid cleared unless reloaded.
- In ARB_RD:
  - ram_addr=rd_ptr, rd_gnt=1;
  - at the edge: rd_ptr++ with wrap, count--.
  - rd_valid=1 the following cycle; rd_data = ram_rdata in that cycle (read latency 1 from rd_gnt).
- In ARB_IDLE: ram_we=0, ram_addr holds its last value.
- starve_cnt:
  - increments (saturating at STARVE_MAX) each cycle both are eligible and ARB_WR is chosen;
  - clears on entry to ARB_RD or when rd_req=0.
- count/pointers: one RAM access per cycle, so count never increments and decrements in the same cycle. Decisions use registered count.
- ovf_clr clears overflow; ovf_clr in the same cycle as a new drop leaves overflow=1 (set wins).
- Reset mid-operation: pending slot, pointers, count, FSM and flags clear immediately; an in-flight rd_valid is suppressed.

Decomposition:
- Package avg_ram_pkg: arb_state_t enum {ARB_IDLE, ARB_WR, ARB_RD}, default AW/DW constants.
- Sub-module avg_ram_ptrs: wr_ptr/rd_ptr/count/full/empty bookkeeping with inc_wr/inc_rd strobes.
- avg_ram_arb keeps the FSM, pending slot, starvation counter and overflow.

Test Plan:
- Reset, then wr_req with wr_data=0x3C, no reads -> ARB_WR next cycle: ram_we=1, ram_addr=0, ram_wdata=0x3C; count=1, empty=0.
- After 3 writes (0x11, 0x22, 0x33), hold rd_req -> three rd_gnt pulses at addr 0, 1, 2; rd_valid the cycle after each, rd_data=0x11, 0x22, 0x33; count returns to 0, empty=1.
- Write DEPTH=16 entries, then a 17th wr_req with no reads -> full=1, count=16, no ram_we for the 17th, overflow=1. ovf_clr pulse -> overflow=0.
- wr_req every cycle with rd_req held and count>0, STARVE_MAX=3 -> exactly 3 consecutive ARB_WR cycles, then one rd_gnt, then the pattern repeats.
- Pointer wrap: 20 writes interleaved with 20 reads -> wr_ptr and rd_ptr wrap 15 -> 0; data read in write order; count never exceeds 16.
- reset_n asserted during ARB_RD with count=5 -> count=0, empty=1, rd_valid=0 next cycle, FSM in ARB_IDLE.
